// File: rtl/bcd_scan_pkg.sv
// Shared constants and helpers for the multiplexed BCD scan driver.
package bcd_scan_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;
    localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_scan_driver_if.sv
// Host/decoder-side signal bundle of bcd_scan_driver.
// Optional macro BCD_SCAN_LAMP_TEST_EN adds the LT_REQ_n lamp-test request.
interface bcd_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    import bcd_scan_pkg::*;

    logic                          EN;
    logic                          LOAD;
    logic [BCD_W*NUM_DIGITS-1:0]   DIN;
    logic                          LZ_SUPPRESS;
`ifdef BCD_SCAN_LAMP_TEST_EN
    logic                          LT_REQ_n;
`endif
    logic                          BCD_D;
    logic                          BCD_C;
    logic                          BCD_B;
    logic                          BCD_A;
    logic                          RBI_n;
    logic                          LT_n;
    logic [NUM_DIGITS-1:0]         DIG_SEL_n;
    logic                          FRAME_DONE;

`ifdef BCD_SCAN_LAMP_TEST_EN
    modport master (
        output EN, LOAD, DIN, LZ_SUPPRESS, LT_REQ_n,
        input  BCD_D, BCD_C, BCD_B, BCD_A, RBI_n, LT_n, DIG_SEL_n, FRAME_DONE
    );
    modport slave (
        input  EN, LOAD, DIN, LZ_SUPPRESS, LT_REQ_n,
        output BCD_D, BCD_C, BCD_B, BCD_A, RBI_n, LT_n, DIG_SEL_n, FRAME_DONE
    );
`else
    modport master (
        output EN, LOAD, DIN, LZ_SUPPRESS,
        input  BCD_D, BCD_C, BCD_B, BCD_A, RBI_n, LT_n, DIG_SEL_n, FRAME_DONE
    );
    modport slave (
        input  EN, LOAD, DIN, LZ_SUPPRESS,
        output BCD_D, BCD_C, BCD_B, BCD_A, RBI_n, LT_n, DIG_SEL_n, FRAME_DONE
    );
`endif

endinterface

// File: rtl/bcd_scan_timer.sv
// Slot prescaler and digit index for the scan driver. The index counts down from the
// most significant digit; dropping the enable parks the current slot at its gap clock.
module bcd_scan_timer
    import bcd_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           en_i,
    output logic [cnt_w(NUM_DIGITS)-1:0]   idx_o,
    output logic                           gap_o,
    output logic                           frame_start_o,
    output logic                           slot_end_o,
    output logic                           frame_end_o
);

    localparam int unsigned PW = cnt_w(SCAN_DIV);
    localparam int unsigned IW = cnt_w(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          slot_end;

    // Next-state: advance while enabled, restart the current slot while disabled.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (!en_i) begin
            presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Counter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            idx_q   <= IDX_LAST;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    assign slot_end      = en_i && (presc_q == PRESC_LAST);
    assign idx_o         = idx_q;
    assign gap_o         = (presc_q == '0);
    assign frame_start_o = en_i && (presc_q == '0) && (idx_q == IDX_LAST);
    assign slot_end_o    = slot_end;
    assign frame_end_o   = slot_end && (idx_q == '0);

endmodule

// File: rtl/bcd_scan_driver.sv
// Multiplexed BCD display driver feeding a 7-segment decoder one nibble per slot.
// Updates are frame-synchronous via a shadow register; leading zeros are blanked via RBI_n.
// Optional macro BCD_SCAN_LAMP_TEST_EN adds a synchronised lamp-test request.
module bcd_scan_driver
    import bcd_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 16
) (
    input  logic               CLK,
    input  logic               CLR_n,
    bcd_scan_driver_if.slave   bus
);

    localparam int unsigned IW = cnt_w(NUM_DIGITS);
    localparam int unsigned DW = BCD_W * NUM_DIGITS;

    logic [IW-1:0]         idx;
    logic                  gap;
    logic                  frame_start;
    logic                  slot_end;
    logic                  frame_end;

    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         display_q, display_d;
    logic                  pending_q, pending_d;
    logic                  blank_q, blank_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic                  rbi_q, rbi_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic                  frame_done_q, frame_done_d;

    logic [DW-1:0]         disp_eff;
    logic                  blank_eff;
    logic [BCD_W-1:0]      digit;
    logic                  lt_active;

    bcd_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_timer (
        .clk_i         (CLK),
        .rst_ni        (CLR_n),
        .en_i          (bus.EN),
        .idx_o         (idx),
        .gap_o         (gap),
        .frame_start_o (frame_start),
        .slot_end_o    (slot_end),
        .frame_end_o   (frame_end)
    );

    // Shadow capture and frame-start transfer; a coincident LOAD stays pending.
    always_comb begin
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        disp_eff  = display_q;
        if (frame_start && pending_q) begin
            display_d = shadow_q;
            disp_eff  = shadow_q;
            pending_d = 1'b0;
        end
        if (bus.LOAD) begin
            shadow_d  = bus.DIN;
            pending_d = 1'b1;
        end
    end

    // Nibble of the digit being scanned, taken from the value shown this frame.
    always_comb begin
        digit = BCD_ZERO;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                digit = disp_eff[i*BCD_W +: BCD_W];
            end
        end
    end

    // Blanking flag and next output values; outputs hold while scanning is disabled.
    always_comb begin
        blank_eff    = frame_start ? bus.LZ_SUPPRESS : blank_q;
        blank_d      = blank_q;
        bcd_d        = bcd_q;
        rbi_d        = rbi_q;
        dig_sel_d    = '1;
        frame_done_d = 1'b0;
        if (frame_start) begin
            blank_d = bus.LZ_SUPPRESS;
        end
        if (bus.EN) begin
            bcd_d        = digit;
            rbi_d        = !(blank_eff && (digit == BCD_ZERO) && (idx != '0));
            frame_done_d = frame_end;
            if (slot_end) begin
                blank_d = blank_q && (digit == BCD_ZERO);
            end
            if (!gap) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx == IW'(i)) begin
                        dig_sel_d[i] = 1'b0;
                    end
                end
            end
        end
        if (lt_active) begin
            dig_sel_d = '0;
            rbi_d     = 1'b1;
        end
    end

    // Data and output registers.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            shadow_q     <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            blank_q      <= 1'b0;
            bcd_q        <= BCD_ZERO;
            rbi_q        <= 1'b1;
            dig_sel_q    <= '1;
            frame_done_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            blank_q      <= blank_d;
            bcd_q        <= bcd_d;
            rbi_q        <= rbi_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef BCD_SCAN_LAMP_TEST_EN
    logic lt_meta_q, lt_meta_d;
    logic lt_sync_q, lt_sync_d;

    // Two-flop synchroniser for the asynchronous lamp-test request.
    always_comb begin
        lt_meta_d = bus.LT_REQ_n;
        lt_sync_d = lt_meta_q;
    end

    // Synchroniser flops; LT_n is the second stage.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            lt_meta_q <= 1'b1;
            lt_sync_q <= 1'b1;
        end else begin
            lt_meta_q <= lt_meta_d;
            lt_sync_q <= lt_sync_d;
        end
    end

    // Forcing follows the value LT_n takes at the same edge, so both change together.
    assign lt_active = !lt_sync_d;
    assign bus.LT_n  = lt_sync_q;
`else
    assign lt_active = 1'b0;
    assign bus.LT_n  = 1'b1;
`endif

    assign {bus.BCD_D, bus.BCD_C, bus.BCD_B, bus.BCD_A} = bcd_q;
    assign bus.RBI_n      = rbi_q;
    assign bus.DIG_SEL_n  = dig_sel_q;
    assign bus.FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Self-checking bench for bcd_scan_driver (NUM_DIGITS=4, SCAN_DIV=4): directed steps
// followed by random traffic, compared against a frame-position reference model.
module tb_bcd_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int FL = ND * SD;

    logic clk = 1'b0;
    logic clr_n = 1'b0;

    bcd_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    bcd_scan_driver #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD)
    ) dut (
        .CLK   (clk),
        .CLR_n (clr_n),
        .bus   (bus)
    );

`ifdef BCD_SCAN_LAMP_TEST_EN
    bit lt_req = 1'b1;
    bit lt1, lt2;
    assign bus.LT_REQ_n = lt_req;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: position within the frame (0..FL-1), the value shown this frame,
    // the pending shadow, and which digits are blanked this frame.
    int          pos;
    logic [15:0] m_shadow;
    logic [15:0] m_disp;
    bit          m_pending;
    bit [ND-1:0] m_blank;
    logic [3:0]  e_bcd;
    logic        e_rbi;
    logic [ND-1:0] e_dig;
    logic        e_fd;
    logic        e_lt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s @cyc%0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    function automatic void model_reset();
        pos = 0; m_shadow = '0; m_disp = '0; m_pending = 1'b0; m_blank = '0;
        e_bcd = 4'd0; e_rbi = 1'b1; e_dig = '1; e_fd = 1'b0; e_lt = 1'b1;
`ifdef BCD_SCAN_LAMP_TEST_EN
        lt1 = 1'b1; lt2 = 1'b1;
`endif
    endfunction

    function automatic void model_edge(input bit en, input bit load, input logic [15:0] din,
                                       input bit lz);
        int d;
        int ph;
`ifdef BCD_SCAN_LAMP_TEST_EN
        lt2 = lt1;
        lt1 = lt_req;
`endif
        if (en) begin
            d  = ND - 1 - pos / SD;
            ph = pos % SD;
            if (pos == 0) begin
                if (m_pending) begin
                    m_disp    = m_shadow;
                    m_pending = 1'b0;
                end
                // A digit is blanked when suppression is on, it is not the units digit,
                // and it and everything above it are zero.
                for (int k = 0; k < ND; k++)
                    m_blank[k] = lz && (k != 0) && ((m_disp >> (4 * k)) == 16'd0);
            end
            e_bcd = m_disp[4*d +: 4];
            e_rbi = !m_blank[d];
            e_dig = '1;
            if (ph != 0) e_dig[d] = 1'b0;
            e_fd = (pos == FL - 1);
            pos  = (pos + 1) % FL;
        end else begin
            e_dig = '1;
            e_fd  = 1'b0;
            pos   = pos - pos % SD;
        end
        if (load) begin
            m_shadow  = din;
            m_pending = 1'b1;
        end
`ifdef BCD_SCAN_LAMP_TEST_EN
        e_lt = lt2;
        if (!lt2) begin
            e_dig = '0;
            e_rbi = 1'b1;
        end
`endif
    endfunction

    task automatic check_outputs();
        chk("bcd", {bus.BCD_D, bus.BCD_C, bus.BCD_B, bus.BCD_A}, e_bcd);
        chk("rbi_n", bus.RBI_n, e_rbi);
        chk("dig_sel_n", bus.DIG_SEL_n, e_dig);
        chk("frame_done", bus.FRAME_DONE, e_fd);
        chk("lt_n", bus.LT_n, e_lt);
    endtask

    task automatic step(input bit en, input bit load, input logic [15:0] din, input bit lz);
        bus.EN = en; bus.LOAD = load; bus.DIN = din; bus.LZ_SUPPRESS = lz;
        @(posedge clk);
        cyc++;
        model_edge(en, load, din, lz);
        #1;
        check_outputs();
    endtask

    task automatic run(input int n, input bit lz);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, lz);
    endtask

    // One full frame from position 0, with the displayed digits and RBI_n written out
    // directly from the expected display contents.
    task automatic frame_check(input string tag, input logic [15:0] val,
                               input logic [3:0] rbi_bits, input bit lz);
        int d;
        logic [3:0] sel;
        for (int i = 0; i < FL; i++) begin
            step(1'b1, 1'b0, 16'h0, lz);
            d = ND - 1 - i / SD;
            sel = 4'b1111;
            if (i % SD != 0) sel[d] = 1'b0;
            chk({tag, "_bcd"}, {bus.BCD_D, bus.BCD_C, bus.BCD_B, bus.BCD_A}, val[4*d +: 4]);
            chk({tag, "_rbi"}, bus.RBI_n, rbi_bits[d]);
            chk({tag, "_sel"}, bus.DIG_SEL_n, sel);
        end
    endtask

    initial begin
        logic [15:0] rdin;
        bus.EN = 1'b0; bus.LOAD = 1'b0; bus.DIN = '0; bus.LZ_SUPPRESS = 1'b0;
        model_reset();
        #12;
        chk("rst_bcd", {bus.BCD_D, bus.BCD_C, bus.BCD_B, bus.BCD_A}, 4'd0);
        chk("rst_rbi", bus.RBI_n, 1'b1);
        chk("rst_lt", bus.LT_n, 1'b1);
        chk("rst_sel", bus.DIG_SEL_n, 4'b1111);
        chk("rst_fd", bus.FRAME_DONE, 1'b0);
        clr_n = 1'b1;

        // 0042 with suppression: two leading zeros blanked.
        step(1'b1, 1'b1, 16'h0042, 1'b1);
        run(FL - 1, 1'b1);
        frame_check("h0042", 16'h0042, 4'b0011, 1'b1);

        // All zero: units digit still shown; without suppression nothing blanked.
        step(1'b1, 1'b1, 16'h0000, 1'b1);
        run(FL - 1, 1'b1);
        frame_check("h0000lz", 16'h0000, 4'b0001, 1'b1);
        frame_check("h0000", 16'h0000, 4'b1111, 1'b0);

        // 1234, then 5678 loaded during the digit-2 slot takes effect next frame.
        step(1'b1, 1'b1, 16'h1234, 1'b0);
        run(FL - 1, 1'b0);
        run(5, 1'b0);
        step(1'b1, 1'b1, 16'h5678, 1'b0);
        run(FL - 6, 1'b0);
        frame_check("h5678", 16'h5678, 4'b1111, 1'b0);

        // Interior zero after a nonzero digit is not blanked.
        step(1'b1, 1'b1, 16'h1020, 1'b1);
        run(FL - 1, 1'b1);
        frame_check("h1020", 16'h1020, 4'b1111, 1'b1);

        // Scan disabled mid digit-1 slot: all digits off, nibble holds, slot restarts.
        run(10, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1);
            chk("en_off_sel", bus.DIG_SEL_n, 4'b1111);
            chk("en_off_bcd", {bus.BCD_D, bus.BCD_C, bus.BCD_B, bus.BCD_A}, 4'd2);
        end
        step(1'b1, 1'b0, 16'h0, 1'b1);
        chk("resume_gap", bus.DIG_SEL_n, 4'b1111);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        chk("resume_sel", bus.DIG_SEL_n, 4'b1101);

        // Asynchronous clear mid-slot.
        clr_n = 1'b0;
        #2;
        chk("clr_bcd", {bus.BCD_D, bus.BCD_C, bus.BCD_B, bus.BCD_A}, 4'd0);
        chk("clr_rbi", bus.RBI_n, 1'b1);
        chk("clr_sel", bus.DIG_SEL_n, 4'b1111);
        chk("clr_fd", bus.FRAME_DONE, 1'b0);
        model_reset();
        clr_n = 1'b1;
        frame_check("after_clr", 16'h0000, 4'b1111, 1'b0);

`ifdef BCD_SCAN_LAMP_TEST_EN
        step(1'b1, 1'b1, 16'h0042, 1'b1);
        run(FL - 1, 1'b1);
        lt_req = 1'b0;
        step(1'b1, 1'b0, 16'h0, 1'b1);
        chk("lt_wait", bus.LT_n, 1'b1);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        chk("lt_on", bus.LT_n, 1'b0);
        chk("lt_sel", bus.DIG_SEL_n, 4'b0000);
        chk("lt_rbi", bus.RBI_n, 1'b1);
        run(6, 1'b1);
        lt_req = 1'b1;
        run(8, 1'b1);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < ND; k++)
                rdin[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
`ifdef BCD_SCAN_LAMP_TEST_EN
            if ($urandom_range(0, 39) == 0) lt_req = ~lt_req;
`endif
            step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, rdin,
                 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_scan_driver.md
Name: bcd_scan_driver

Overview:
- Multi-digit multiplexed BCD display driver.
- Sits directly upstream of the BCD-to-7-segment decoder (74LS48 equivalent). Feeds it one BCD nibble at a time (BCD_D..BCD_A) plus RBI_n, and drives the active-low common digit enables.
- Provides frame-synchronous (tear-free) data update and leading-zero suppression through the decoder's ripple-blanking input.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8); digit NUM_DIGITS-1 is most significant.
- SCAN_DIV, 16, clocks per digit slot (>=2); slot cycle 0 is an anti-ghost gap.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR_n  in  1  asynchronous active-low reset.
- EN  in  1  scan enable.
- LOAD  in  1  1-cycle strobe; capture DIN into shadow register.
- DIN  in  4*NUM_DIGITS  packed BCD; nibble i is digit i.
- LZ_SUPPRESS  in  1  1 = blank leading zeros.
- BCD_D, BCD_C, BCD_B, BCD_A  out  1 each  current digit nibble (D = MSB).
- RBI_n  out  1  ripple-blank request to decoder.
- LT_n  out  1  lamp-test to decoder.
- DIG_SEL_n  out  NUM_DIGITS  one-cold digit enable.
- FRAME_DONE  out  1  1-cycle pulse at end of frame.

Behaviour:
- Interface fixed: one clock CLK; CLR_n asynchronous, active-low.
- Reset values:
  - presc=0, idx=NUM_DIGITS-1; shadow, display register, pending and blank_flag all 0.
  - BCD_*=0, RBI_n=1, LT_n=1, DIG_SEL_n all 1, FRAME_DONE=0.
- Reset mid-frame: immediate return to reset values; display data lost.
- All outputs are registered and lag counter state by one clock.
- Scan counters:
  - presc counts 0..SCAN_DIV-1 while EN=1.
  - At wrap, idx decrements NUM_DIGITS-1 → 0, then wraps to NUM_DIGITS-1.
  - The first slot begins on the first rising edge with EN=1 after CLR_n deasserts.
- Slot timing:
  - BCD_* and RBI_n are valid for all SCAN_DIV clocks of the slot.
  - DIG_SEL_n is all 1 on the gap clock (presc=0).
  - DIG_SEL_n[idx]=0 on the remaining SCAN_DIV-1 clocks.
- Frame start (idx=NUM_DIGITS-1, presc=0, EN=1):
  - If pending=1: display ← shadow, pending ← 0.
  - blank_flag ← LZ_SUPPRESS.
- LOAD: shadow ← DIN, pending ← 1, accepted regardless of EN.
  - LOAD coincident with frame start: the transfer uses the old shadow; the new value stays pending for the next frame.
- Leading-zero suppression, per slot:
  - RBI_n = 0 iff blank_flag=1, digit==0 and idx≠0.
  - At slot end: blank_flag ← blank_flag AND (digit==0).
  - Digit 0 is never blanked, so an all-zero value shows "0".
- Codes 10..15 pass through unmodified and never clear or set blank_flag differently from a nonzero digit.
- EN=0:
  - presc and idx freeze; DIG_SEL_n forced all 1 on the next edge.
  - BCD_* and RBI_n hold.
  - Resuming EN=1 restarts the current slot at its gap clock (presc reset to 0).
- FRAME_DONE: high for exactly one clock, aligned with the last clock of the digit-0 slot.

Optional Feature:
- Macro BCD_SCAN_LAMP_TEST_EN.
- Defined:
  - Adds input LT_REQ_n (1 bit).
  - LT_n is the 2-flop-synchronised LT_REQ_n.
  - While LT_n=0: all DIG_SEL_n=0 (all digits lit, no gap clock); scan counters keep running; RBI_n forced to 1.
- Undefined: LT_REQ_n does not exist; LT_n is constant 1.

Decomposition:
- Package bcd_scan_pkg: BCD_W=4, BCD_ZERO=4'd0, BCD_MAX=4'd9, and the width helper for presc/idx.
- Sub-module bcd_scan_timer: presc and idx counters, EN freeze, frame_start and frame_end strobes.
- bcd_scan_driver contains the shadow/display registers, blanking logic and output registers.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4 unless stated):
- Load 16'h0042 with LZ_SUPPRESS=1 → frame after transfer:
  - digit3: BCD=0, RBI_n=0.
  - digit2: BCD=0, RBI_n=0.
  - digit1: BCD=4, RBI_n=1.
  - digit0: BCD=2, RBI_n=1.
  - Each slot: DIG_SEL_n=1111 on the gap clock, then 0111/1011/1101/1110 for 3 clocks.
- Load 16'h0000 with LZ_SUPPRESS=1 → digits 3..1 RBI_n=0; digit0 BCD=0, RBI_n=1. Repeat with LZ_SUPPRESS=0 → RBI_n=1 on all four slots.
- Load 16'h1234, then mid-frame (during digit2 slot) load 16'h5678:
  - Remainder of the frame shows 2,3,4.
  - Next frame shows 5,6,7,8.
  - FRAME_DONE pulses once per 16 clocks.
- Load 16'h1020 with LZ_SUPPRESS=1 → digit2 (value 0) shows RBI_n=1, because blank_flag is cleared by digit3=1.
- EN dropped for 10 clocks during digit1 slot:
  - DIG_SEL_n=1111 and BCD holds 2.
  - On resume, the digit1 slot restarts with a gap clock.
  - Assert CLR_n=0 mid-slot → all outputs return to reset values asynchronously.
- With BCD_SCAN_LAMP_TEST_EN defined, drive LT_REQ_n=0 → after 2 clocks LT_n=0, DIG_SEL_n=0000, RBI_n=1; release restores normal scan.
